// File: rtl/fact_pkg.sv
// Shared types and default sizing for the factorial job sequencer.
package fact_pkg;

   localparam int unsigned FACT_DW          = 16;
   localparam int unsigned FACT_MAX_N       = 8;
   localparam int unsigned FACT_TIMEOUT_CYC = 1023;
   localparam int unsigned STAT_W           = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage : fact_pkg

// File: rtl/fact_timeout_ctr.sv
// Watchdog counter: clear/enable, saturating, with a terminal-count flag that
// fires during the TIMEOUT_CYC-th enabled cycle after a clear.
module fact_timeout_ctr
   import fact_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = FACT_TIMEOUT_CYC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_c_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count enabled cycles, hold at TIMEOUT_CYC, restart on clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CW'(TIMEOUT_CYC))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc_c_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule : fact_timeout_ctr

// File: rtl/fact_job_sequencer.sv
// Requester side of the factorial engine: accepts an operand, range-checks it,
// launches the engine, waits for a Done rising edge (with watchdog) and returns
// result/error on a valid/ready stream.
// Optional job statistics counters are built when FACT_STATS_EN is defined.
module fact_job_sequencer
   import fact_pkg::*;
#(
   parameter int unsigned DW          = FACT_DW,
   parameter int unsigned MAX_N       = FACT_MAX_N,
   parameter int unsigned TIMEOUT_CYC = FACT_TIMEOUT_CYC
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DW-1:0]     req_data,
   output logic              eng_start,
   output logic [DW-1:0]     eng_data,
   input  logic [DW-1:0]     eng_out,
   input  logic              eng_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [STAT_W-1:0] stat_ok,
   output logic [STAT_W-1:0] stat_err
);

   state_e          state_q, state_d;
   logic            req_ready_q, req_ready_d;
   logic            eng_start_q, eng_start_d;
   logic [DW-1:0]   eng_data_q, eng_data_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic            busy_q, busy_d;
   logic            done_q;
   logic            done_rise_c;
   logic            wd_clr_c, wd_en_c, wd_tc_c;

   fact_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wd (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (wd_clr_c),
      .en_i   (wd_en_c),
      .tc_c_o (wd_tc_c)
   );

   // A Done still high from an earlier job never counts; only a fresh edge does.
   assign done_rise_c = eng_done & ~done_q;

   // Next-state and registered-output decode.
   always_comb begin
      state_d    = state_q;
      eng_data_d = eng_data_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      wd_clr_c   = 1'b0;
      wd_en_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_data > DW'(MAX_N)) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                  state_d    = RESP;
               end else begin
                  eng_data_d = req_data;
                  state_d    = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            wd_clr_c = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            wd_en_c = 1'b1;
            // Completion takes priority over a simultaneous timeout.
            if (done_rise_c) begin
               rsp_data_d = eng_out;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (wd_tc_c) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
      eng_start_d = (state_d == LAUNCH);
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers; reset drops everything, req_ready rises on the first clock after.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         eng_start_q <= 1'b0;
         eng_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         eng_start_q <= eng_start_d;
         eng_data_q  <= eng_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         done_q      <= eng_done;
      end
   end

   assign req_ready = req_ready_q;
   assign eng_start = eng_start_q;
   assign eng_data  = eng_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

`ifdef FACT_STATS_EN
   logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
   logic [STAT_W-1:0] stat_err_q, stat_err_d;
   logic              rsp_hs_c;

   // Saturating job counters, bumped on each response handshake.
   always_comb begin
      rsp_hs_c   = (state_q == RESP) && rsp_ready;
      stat_ok_d  = stat_ok_q;
      stat_err_d = stat_err_q;
      if (rsp_hs_c) begin
         if (rsp_err_q) begin
            if (stat_err_q != '1) stat_err_d = stat_err_q + STAT_W'(1);
         end else begin
            if (stat_ok_q != '1) stat_ok_d = stat_ok_q + STAT_W'(1);
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stat_ok_q  <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ok_q  <= stat_ok_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_ok  = stat_ok_q;
   assign stat_err = stat_err_q;
`else
   assign stat_ok  = '0;
   assign stat_err = '0;
`endif

endmodule : fact_job_sequencer

// File: tb/tb_fact_job_sequencer.sv
// Bench for fact_job_sequencer: engine modelled as n! after a programmable
// delay with Done held high until the next Start.
module tb_fact_job_sequencer;

   localparam int MAX_N   = 8;
   localparam int TIMEOUT = 1023;

   logic        CLK;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_data;
   logic        eng_start;
   logic [15:0] eng_data;
   logic [15:0] eng_out;
   logic        eng_done;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [15:0] stat_ok;
   logic [15:0] stat_err;

   int total;
   int bad;
   int start_cnt;
   int exp_ok;
   int exp_err;

   // engine model controls
   int   eng_delay;
   logic eng_never;
   logic e_busy;
   int   e_cnt;
   int   e_n;

   typedef struct {
      int          n;
      int          delay;   // -1: engine never completes
      int          hold;    // cycles rsp_ready stays low
      logic [15:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t vecs[6];

   fact_job_sequencer dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .eng_start (eng_start),
      .eng_data  (eng_data),
      .eng_out   (eng_out),
      .eng_done  (eng_done),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .stat_ok   (stat_ok),
      .stat_err  (stat_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] ref_fact(input int n);
      int unsigned p;
      p = 1;
      for (int i = 2; i <= n; i++) p = p * i;
      return 16'(p);
   endfunction

   // Engine: Start drops Done and restarts; Done rises `eng_delay` edges later.
   always @(posedge CLK) begin
      if (eng_start) begin
         eng_done <= 1'b0;
         e_busy   <= 1'b1;
         e_cnt    <= eng_delay;
         e_n      <= int'(eng_data);
      end else if (e_busy && !eng_never) begin
         if (e_cnt <= 1) begin
            eng_done <= 1'b1;
            eng_out  <= ref_fact(e_n);
            e_busy   <= 1'b0;
         end else begin
            e_cnt <= e_cnt - 1;
         end
      end
   end

   always @(posedge CLK) if (eng_start) start_cnt <= start_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_stats();
`ifdef FACT_STATS_EN
      chk("stat_ok", 32'(stat_ok), 32'(exp_ok));
      chk("stat_err", 32'(stat_err), 32'(exp_err));
`else
      chk("stat_ok_tied", 32'(stat_ok), 32'd0);
      chk("stat_err_tied", 32'(stat_err), 32'd0);
`endif
   endtask

   // One full job: request, launch/latency checks, response hold, handshake.
   task automatic run_job(input int n, input int delay, input int hold,
                          input logic [15:0] exp_d, input logic exp_e);
      int          w;
      int          exp_lat;
      logic [15:0] d0;
      logic        e0;
      eng_never = (delay < 0);
      eng_delay = (delay < 0) ? 1 : delay;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge CLK);
         w++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      start_cnt = 0;
      req_valid = 1'b1;
      req_data  = 16'(n);
      @(negedge CLK);
      req_valid = 1'b0;
      req_data  = 16'($urandom);
      if (n <= MAX_N) begin
         chk("eng_start_launch", 32'(eng_start), 32'd1);
         chk("eng_data_launch", 32'(eng_data), 32'(n));
         exp_lat = (delay < 0) ? TIMEOUT + 1 : delay + 2;
      end else begin
         chk("eng_start_none", 32'(eng_start), 32'd0);
         exp_lat = 0;
      end
      w = 0;
      while (!rsp_valid && w < TIMEOUT + 100) begin
         @(negedge CLK);
         w++;
      end
      chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      chk("rsp_latency", 32'(w), 32'(exp_lat));
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("rsp_err", 32'(rsp_err), 32'(exp_e));
      chk("busy_resp", {busy, req_ready}, 2'b10);
      if (n <= MAX_N) chk("eng_data_held", 32'(eng_data), 32'(n));
      d0 = rsp_data;
      e0 = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         chk("rsp_hold", {rsp_valid, req_ready, rsp_err, rsp_data}, {1'b1, 1'b0, e0, d0});
      end
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", {rsp_valid, busy, req_ready}, 3'b001);
      chk("start_count", 32'(start_cnt), (n <= MAX_N) ? 32'd1 : 32'd0);
      if (exp_e) exp_err++;
      else       exp_ok++;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout bench did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int d;
      int h;
      total     = 0;
      bad       = 0;
      exp_ok    = 0;
      exp_err   = 0;
      start_cnt = 0;
      eng_delay = 1;
      eng_never = 1'b0;
      e_busy    = 1'b0;
      e_cnt     = 0;
      e_n       = 0;
      eng_done  = 1'b0;
      eng_out   = '0;
      RST       = 1'b1;
      req_valid = 1'b0;
      req_data  = '0;
      rsp_ready = 1'b0;

      vecs[0] = '{n: 5, delay: 20, hold: 0, exp_d: 16'd120,   exp_e: 1'b0};
      vecs[1] = '{n: 0, delay: 3,  hold: 0, exp_d: 16'd1,     exp_e: 1'b0};
      vecs[2] = '{n: 8, delay: 4,  hold: 0, exp_d: 16'd40320, exp_e: 1'b0};
      vecs[3] = '{n: 9, delay: 5,  hold: 0, exp_d: 16'd0,     exp_e: 1'b1};
      vecs[4] = '{n: 7, delay: -1, hold: 0, exp_d: 16'd0,     exp_e: 1'b1};
      vecs[5] = '{n: 4, delay: 2,  hold: 10, exp_d: 16'd24,   exp_e: 1'b0};

      // reset state
      @(negedge CLK);
      chk("reset_outputs", {req_ready, eng_start, eng_data, rsp_valid, rsp_data, rsp_err, busy},
          35'd0);
      chk_stats();
      RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_reset", {req_ready, busy}, 2'b10);

      // directed jobs (first five cover the basic, back-to-back, range and timeout cases)
      for (int i = 0; i < 5; i++)
         run_job(vecs[i].n, vecs[i].delay, vecs[i].hold, vecs[i].exp_d, vecs[i].exp_e);
      chk_stats();

      // response backpressure
      run_job(vecs[5].n, vecs[5].delay, vecs[5].hold, vecs[5].exp_d, vecs[5].exp_e);

      // randomized jobs against the arithmetic reference
      for (int i = 0; i < 24; i++) begin
         n = int'($urandom_range(0, 11));
         if ($urandom_range(0, 9) == 0) d = -1;
         else                           d = int'($urandom_range(1, 15));
         h = int'($urandom_range(0, 3));
         if (n > MAX_N || d < 0) run_job(n, d, h, 16'd0, 1'b1);
         else                    run_job(n, d, h, ref_fact(n), 1'b0);
      end
      chk_stats();

      // asynchronous reset in the middle of WAIT
      eng_never = 1'b0;
      eng_delay = 50;
      req_valid = 1'b1;
      req_data  = 16'd3;
      @(negedge CLK);
      req_valid = 1'b0;
      repeat (5) @(negedge CLK);
      chk("busy_before_reset", 32'(busy), 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("async_reset_outputs", {req_ready, eng_start, eng_data, rsp_valid, rsp_data, rsp_err, busy},
          35'd0);
      exp_ok  = 0;
      exp_err = 0;
      chk_stats();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_mid_reset", {req_ready, busy}, 2'b10);
      run_job(3, 6, 0, 16'd6, 1'b0);
      chk_stats();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fact_job_sequencer
